// File: rtl/joystick_dir_decoder.sv
// Joystick direction decoder: polls a dual-channel ADC, block-averages X/Y,
// classifies against a deadzone and emits direction levels plus auto-repeat events.
// Optional macro JOY_AUTO_CAL_EN: the first average after reset becomes the centre.
module joystick_dir_decoder #(
  parameter int POLL_DIV     = 50000,
  parameter int AVG_LOG2     = 2,
  parameter int CENTER       = 512,
  parameter int DEADZONE     = 150,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       adc_start,
  input  logic [9:0] adc_x,
  input  logic [9:0] adc_y,
  input  logic       adc_valid,
  output logic [9:0] x_avg,
  output logic [9:0] y_avg,
  output logic       avg_valid,
  output logic       dir_up,
  output logic       dir_down,
  output logic       dir_left,
  output logic       dir_right,
  output logic       dir_event,
  output logic [2:0] dir_code
);

  localparam int PC_W   = $clog2(POLL_DIV);
  localparam int ACC_W  = 10 + AVG_LOG2;
  localparam int SC_W   = AVG_LOG2 + 1;
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W   = $clog2(RC_MAX) + 1;

  localparam logic [PC_W-1:0] POLL_LAST  = PC_W'(POLL_DIV - 1);
  localparam logic [SC_W-1:0] SAMP_LAST  = SC_W'((1 << AVG_LOG2) - 1);
  localparam logic [RC_W-1:0] DELAY_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RATE_LAST  = RC_W'(REPEAT_RATE - 1);
  localparam logic signed [10:0] DZ_POS  = 11'(DEADZONE);
  localparam logic signed [10:0] DZ_NEG  = 11'(-DEADZONE);

  typedef enum logic [1:0] {NEUTRAL, HELD, REPEAT} state_t;

  logic [PC_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic             busy_q, busy_d;
  logic             start_now;
  logic [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [ACC_W-1:0] sum_x, sum_y;
  logic [SC_W-1:0]  samp_cnt_q, samp_cnt_d;
  logic [9:0]       x_avg_q, x_avg_d, y_avg_q, y_avg_d;
  logic             avg_valid_q, avg_valid_d;
  logic [9:0]       ctr_x, ctr_y;
  logic             cls_en;
  logic signed [10:0] dx, dy, adx, ady;
  logic             lv_up, lv_down, lv_left, lv_right;
  logic [2:0]       code;
  state_t           state_q, state_d;
  logic [RC_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [3:0]       lvl_q, lvl_d;
  logic             dir_event_q, dir_event_d;
  logic [2:0]       dir_code_q, dir_code_d;

  // Poll timer: the counter parks on its last value while a request is outstanding.
  always_comb begin
    start_now  = (poll_cnt_q == POLL_LAST) && !busy_q;
    poll_cnt_d = poll_cnt_q;
    busy_d     = busy_q;
    if (poll_cnt_q != POLL_LAST) begin
      poll_cnt_d = poll_cnt_q + 1'b1;
    end else if (!busy_q) begin
      poll_cnt_d = '0;
    end
    if (start_now) begin
      busy_d = 1'b1;
    end else if (adc_valid) begin
      busy_d = 1'b0;
    end
  end

  assign sum_x = acc_x_q + ACC_W'(adc_x);
  assign sum_y = acc_y_q + ACC_W'(adc_y);

  always_comb begin
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    samp_cnt_d  = samp_cnt_q;
    x_avg_d     = x_avg_q;
    y_avg_d     = y_avg_q;
    avg_valid_d = 1'b0;
    if (adc_valid) begin
      if (samp_cnt_q == SAMP_LAST) begin
        x_avg_d     = 10'(sum_x >> AVG_LOG2);
        y_avg_d     = 10'(sum_y >> AVG_LOG2);
        avg_valid_d = 1'b1;
        acc_x_d     = '0;
        acc_y_d     = '0;
        samp_cnt_d  = '0;
      end else begin
        acc_x_d    = sum_x;
        acc_y_d    = sum_y;
        samp_cnt_d = samp_cnt_q + 1'b1;
      end
    end
  end

`ifdef JOY_AUTO_CAL_EN
  logic       cal_done_q, cal_done_d;
  logic [9:0] ctr_x_q, ctr_x_d, ctr_y_q, ctr_y_d;

  always_comb begin
    cal_done_d = cal_done_q;
    ctr_x_d    = ctr_x_q;
    ctr_y_d    = ctr_y_q;
    if (avg_valid_q && !cal_done_q) begin
      cal_done_d = 1'b1;
      ctr_x_d    = x_avg_q;
      ctr_y_d    = y_avg_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_done_q <= 1'b0;
      ctr_x_q    <= 10'(CENTER);
      ctr_y_q    <= 10'(CENTER);
    end else begin
      cal_done_q <= cal_done_d;
      ctr_x_q    <= ctr_x_d;
      ctr_y_q    <= ctr_y_d;
    end
  end

  assign ctr_x  = ctr_x_q;
  assign ctr_y  = ctr_y_q;
  assign cls_en = avg_valid_q && cal_done_q;
`else
  assign ctr_x  = 10'(CENTER);
  assign ctr_y  = 10'(CENTER);
  assign cls_en = avg_valid_q;
`endif

  // Classification; on a magnitude tie the horizontal axis wins.
  always_comb begin
    dx       = $signed({1'b0, x_avg_q}) - $signed({1'b0, ctr_x});
    dy       = $signed({1'b0, y_avg_q}) - $signed({1'b0, ctr_y});
    adx      = (dx < 0) ? -dx : dx;
    ady      = (dy < 0) ? -dy : dy;
    lv_right = dx > DZ_POS;
    lv_left  = dx < DZ_NEG;
    lv_up    = dy > DZ_POS;
    lv_down  = dy < DZ_NEG;
    if (!(lv_right || lv_left || lv_up || lv_down)) begin
      code = 3'd0;
    end else if (adx >= ady) begin
      code = lv_right ? 3'd4 : 3'd3;
    end else begin
      code = lv_up ? 3'd1 : 3'd2;
    end
  end

  always_comb begin
    state_d     = state_q;
    rep_cnt_d   = rep_cnt_q;
    lvl_d       = lvl_q;
    dir_event_d = 1'b0;
    dir_code_d  = dir_code_q;
    if (cls_en) begin
      lvl_d = {lv_up, lv_down, lv_left, lv_right};
      if (code == 3'd0) begin
        state_d    = NEUTRAL;
        rep_cnt_d  = '0;
        dir_code_d = 3'd0;
      end else if (state_q == NEUTRAL || code != dir_code_q) begin
        state_d     = HELD;
        rep_cnt_d   = '0;
        dir_event_d = 1'b1;
        dir_code_d  = code;
      end else begin
        case (state_q)
          HELD: begin
            if (rep_cnt_q == DELAY_LAST) begin
              state_d     = REPEAT;
              rep_cnt_d   = '0;
              dir_event_d = 1'b1;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
          REPEAT: begin
            if (rep_cnt_q == RATE_LAST) begin
              rep_cnt_d   = '0;
              dir_event_d = 1'b1;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
          default: begin
            state_d   = NEUTRAL;
            rep_cnt_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt_q  <= '0;
      busy_q      <= 1'b0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      samp_cnt_q  <= '0;
      x_avg_q     <= '0;
      y_avg_q     <= '0;
      avg_valid_q <= 1'b0;
      state_q     <= NEUTRAL;
      rep_cnt_q   <= '0;
      lvl_q       <= '0;
      dir_event_q <= 1'b0;
      dir_code_q  <= '0;
    end else begin
      poll_cnt_q  <= poll_cnt_d;
      busy_q      <= busy_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      samp_cnt_q  <= samp_cnt_d;
      x_avg_q     <= x_avg_d;
      y_avg_q     <= y_avg_d;
      avg_valid_q <= avg_valid_d;
      state_q     <= state_d;
      rep_cnt_q   <= rep_cnt_d;
      lvl_q       <= lvl_d;
      dir_event_q <= dir_event_d;
      dir_code_q  <= dir_code_d;
    end
  end

  assign adc_start = start_now;
  assign x_avg     = x_avg_q;
  assign y_avg     = y_avg_q;
  assign avg_valid = avg_valid_q;
  assign dir_up    = lvl_q[3];
  assign dir_down  = lvl_q[2];
  assign dir_left  = lvl_q[1];
  assign dir_right = lvl_q[0];
  assign dir_event = dir_event_q;
  assign dir_code  = dir_code_q;

endmodule

// File: tb/tb_joystick_dir_decoder.sv
// Testbench for joystick_dir_decoder: ADC responder, behavioural reference model,
// per-cycle compare and directed checks, followed by a randomized run.
module tb_joystick_dir_decoder;

  localparam int POLL_DIV = 10;
  localparam int AVG_LOG2 = 2;
  localparam int CENTER   = 512;
  localparam int DZ       = 150;
  localparam int RD       = 3;
  localparam int RR       = 2;
  localparam int NAVG     = 1 << AVG_LOG2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       adc_start;
  logic [9:0] adc_x = '0, adc_y = '0;
  logic       adc_valid = 1'b0;
  logic [9:0] x_avg, y_avg;
  logic       avg_valid;
  logic       dir_up, dir_down, dir_left, dir_right, dir_event;
  logic [2:0] dir_code;

  joystick_dir_decoder #(
    .POLL_DIV(POLL_DIV), .AVG_LOG2(AVG_LOG2), .CENTER(CENTER), .DEADZONE(DZ),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_start(adc_start), .adc_x(adc_x), .adc_y(adc_y),
    .adc_valid(adc_valid), .x_avg(x_avg), .y_avg(y_avg), .avg_valid(avg_valid),
    .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
    .dir_event(dir_event), .dir_code(dir_code)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // stimulus controls
  bit answer_en = 1'b1;
  bit rand_lat = 1'b0;
  bit rand_mode = 1'b0;
  bit check_period = 1'b0;
  int fixed_lat = 3;
  int cur_x = 512, cur_y = 512;
  int sq_x[$], sq_y[$];

  // reference model state
  int  m_sum_x = 0, m_sum_y = 0, m_n = 0;
  bit  cls_pend = 1'b0;
  int  pend_x = 0, pend_y = 0;
  bit  exp_avg_valid = 1'b0, exp_event = 1'b0;
  int  exp_x = 0, exp_y = 0, exp_code = 0, hold_len = 0;
  bit  exp_up = 1'b0, exp_down = 1'b0, exp_left = 1'b0, exp_right = 1'b0;
  int  n_valid_r = 0;
  int  last_valid_cyc = -100;

  // observation bookkeeping
  int cyc = 0;
  int n_start_r = 0;
  int last_start = -1;
  int avg_num = 0;
  int ev_mask = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic int pick_val();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 361;
      2: return 362;
      3: return 512;
      4: return 662;
      5: return 663;
      6: return 1023;
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  // Classification from the rules, with auto-repeat expressed as hold length.
  task automatic model_classify(input int x, input int y);
    int dx, dy, adx, ady, code;
    bit fire;
    dx = x - CENTER;
    dy = y - CENTER;
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    exp_right = dx > DZ;
    exp_left  = dx < -DZ;
    exp_up    = dy > DZ;
    exp_down  = dy < -DZ;
    if (!(exp_right || exp_left || exp_up || exp_down)) code = 0;
    else if (adx >= ady) code = exp_right ? 4 : 3;
    else code = exp_up ? 1 : 2;
    if (code == 0) begin
      hold_len = 0;
      exp_code = 0;
    end else begin
      if (hold_len > 0 && code == exp_code) hold_len++;
      else hold_len = 1;
      fire = (hold_len == 1) || (hold_len == 1 + RD) ||
             (hold_len > 1 + RD && ((hold_len - 1 - RD) % RR) == 0);
      if (fire) begin
        exp_event = 1'b1;
        exp_code  = code;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_avg(input int target);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (avg_num >= target) return;
    end
    chk("wait_avg_timeout", avg_num, target);
  endtask

  task automatic wait_valids(input int target);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (n_valid_r >= target) return;
    end
    chk("wait_valid_timeout", n_valid_r, target);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_adc_start"}, int'(adc_start), 0);
    chk({tag, "_avg_valid"}, int'(avg_valid), 0);
    chk({tag, "_x_avg"}, int'(x_avg), 0);
    chk({tag, "_y_avg"}, int'(y_avg), 0);
    chk({tag, "_levels"}, int'({dir_up, dir_down, dir_left, dir_right}), 0);
    chk({tag, "_dir_event"}, int'(dir_event), 0);
    chk({tag, "_dir_code"}, int'(dir_code), 0);
  endtask

  initial begin
    fork
      // ADC driver model
      begin
        int pend = 0;
        forever begin
          @(negedge clk);
          adc_valid = 1'b0;
          if (!rst_n) begin
            pend = 0;
          end else begin
            if (pend > 0) begin
              pend--;
              if (pend == 0) begin
                int vx, vy;
                if (sq_x.size() > 0) begin
                  vx = sq_x.pop_front();
                  vy = sq_y.pop_front();
                end else if (rand_mode) begin
                  if ($urandom_range(0, 3) == 0) cur_x = pick_val();
                  if ($urandom_range(0, 3) == 0) cur_y = pick_val();
                  vx = cur_x;
                  vy = cur_y;
                end else begin
                  vx = cur_x;
                  vy = cur_y;
                end
                adc_x = 10'(vx);
                adc_y = 10'(vy);
                adc_valid = 1'b1;
              end
            end
            if (adc_start && answer_en)
              pend = rand_lat ? int'($urandom_range(1, 12)) : fixed_lat;
          end
        end
      end
      // reference model, updated on the same edges the DUT registers on
      begin
        forever begin
          @(posedge clk or negedge rst_n);
          if (!rst_n) begin
            m_sum_x = 0; m_sum_y = 0; m_n = 0; cls_pend = 1'b0;
            exp_avg_valid = 1'b0; exp_event = 1'b0;
            exp_x = 0; exp_y = 0; exp_code = 0; hold_len = 0;
            exp_up = 1'b0; exp_down = 1'b0; exp_left = 1'b0; exp_right = 1'b0;
            n_valid_r = 0;
          end else begin
            exp_avg_valid = 1'b0;
            exp_event = 1'b0;
            if (cls_pend) begin
              model_classify(pend_x, pend_y);
              cls_pend = 1'b0;
            end
            if (adc_valid) begin
              n_valid_r++;
              last_valid_cyc = cyc;
              m_sum_x += int'(adc_x);
              m_sum_y += int'(adc_y);
              m_n++;
              if (m_n == NAVG) begin
                exp_avg_valid = 1'b1;
                exp_x = m_sum_x / NAVG;
                exp_y = m_sum_y / NAVG;
                pend_x = exp_x;
                pend_y = exp_y;
                cls_pend = 1'b1;
                m_sum_x = 0; m_sum_y = 0; m_n = 0;
              end
            end
          end
        end
      end
      // per-cycle compare
      begin
        forever begin
          @(negedge clk);
          cyc++;
          chk("avg_valid", int'(avg_valid), int'(exp_avg_valid));
          chk("x_avg", int'(x_avg), exp_x);
          chk("y_avg", int'(y_avg), exp_y);
          chk("levels", int'({dir_up, dir_down, dir_left, dir_right}),
              int'({exp_up, exp_down, exp_left, exp_right}));
          chk("dir_event", int'(dir_event), int'(exp_event));
          chk("dir_code", int'(dir_code), exp_code);
          if (!rst_n) begin
            n_start_r = 0; last_start = -1; avg_num = 0; ev_mask = 0;
          end else begin
            if (adc_start) begin
              chk("no_double_start", int'(n_start_r <= n_valid_r), 1);
              if (check_period && last_start >= 0)
                chk("poll_period", cyc - last_start, POLL_DIV);
              last_start = cyc;
              n_start_r++;
            end
            if (avg_valid) avg_num++;
            if (dir_event && avg_num < 31) ev_mask |= (1 << avg_num);
          end
        end
      end
      // directed and random sequence
      begin
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        #1 rst_n = 1'b1;

        check_period = 1'b1;
        repeat (70) @(posedge clk);
        #1 chk("poll_start_count", int'(n_start_r >= 6), 1);
        check_period = 1'b0;

        answer_en = 1'b0;
        do_reset();
        repeat (80) @(posedge clk);
        #1 chk("no_answer_one_start", n_start_r, 1);
        answer_en = 1'b1;

        do_reset();
        for (int i = 1; i <= 4; i++) begin
          sq_x.push_back(100 * i);
          sq_y.push_back(512);
        end
        wait_avg(1);
        chk("avg_250", int'(x_avg), 250);
        chk("avg_latency", cyc - last_valid_cyc, 1);

        do_reset();
        sq_x = '{1, 1, 1, 2};
        sq_y = '{512, 512, 512, 512};
        wait_avg(1);
        chk("avg_trunc", int'(x_avg), 1);

        do_reset();
        cur_x = 662; cur_y = 512;
        wait_avg(2);
        @(negedge clk); #1;
        chk("dz_662_right", int'(dir_right), 0);
        chk("dz_662_events", ev_mask, 0);
        cur_x = 663;
        wait_avg(3);
        @(negedge clk); #1;
        chk("dz_663_right", int'(dir_right), 1);
        chk("dz_663_event", int'(dir_event), 1);
        chk("dz_663_code", int'(dir_code), 4);
        chk("dz_663_latency", cyc - last_valid_cyc, 2);

        do_reset();
        cur_x = 1023; cur_y = 512;
        wait_avg(9);
        @(negedge clk); #1;
        chk("repeat_mask", ev_mask, 'h152);
        cur_x = 512;
        wait_avg(10);
        @(negedge clk); #1;
        chk("release_right", int'(dir_right), 0);
        chk("release_code", int'(dir_code), 0);
        chk("release_mask", ev_mask, 'h152);

        do_reset();
        sq_x = '{1023, 1023, 1023, 1023};
        sq_y = '{1023, 1023, 1023, 1023};
        cur_x = 700; cur_y = 1023;
        wait_avg(1);
        @(negedge clk); #1;
        chk("diag_levels", int'({dir_up, dir_down, dir_left, dir_right}), 'b1001);
        chk("diag_code", int'(dir_code), 4);
        wait_avg(2);
        @(negedge clk); #1;
        chk("diag_change_event", int'(dir_event), 1);
        chk("diag_change_code", int'(dir_code), 1);

        do_reset();
        cur_x = 1023; cur_y = 1023;
        wait_valids(2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_valids(3);
        repeat (POLL_DIV) @(posedge clk);
        #1 chk("midreset_no_early_avg", avg_num, 0);
        wait_avg(1);
        chk("midreset_fresh_samples", n_valid_r, 4);

        do_reset();
        rand_mode = 1'b1;
        rand_lat = 1'b1;
        wait_avg(60);
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    join_any
  end

endmodule
